// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port (wa3/wd3/we3)
// among NREQ valid/ready requesters. The winning request is registered and
// presented to the register file one cycle after the handshake. Writes to
// register 0 are dropped (flagged on zero_drop) and committed writes are
// counted with a saturating 16-bit counter.
module regfile_wr_arbiter #(
  parameter int N    = 8,
  parameter int NREQ = 3,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*N-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        wa3,
  output logic [N-1:0]         wd3,
  output logic                 we3,
  output logic [1:0]           grant_id,
  output logic                 zero_drop,
  output logic [15:0]          wr_count
);

  // Index of the last granted requester; the scan starts just after it.
  logic [1:0]      r_ptr;

  logic [AW-1:0]   r_wa3_p0;
  logic [N-1:0]    r_wd3_p0;
  logic            r_we3_p0;
  logic [1:0]      r_gid_p0;
  logic            r_zd_p0;
  logic [15:0]     r_cnt;

  logic [NREQ-1:0] w_ready;
  logic            w_found;
  logic [1:0]      w_gnt;
  logic [1:0]      w_idx;
  logic [AW-1:0]   w_addr;
  logic [N-1:0]    w_data;

  // Requester index reached k steps after pointer p, wrapping at NREQ.
  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NREQ;
    return s[1:0];
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Rotating-priority scan: first valid requester after the pointer wins.
  always_comb begin
    w_ready = '0;
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    if (rst && !stall) begin
      for (int k = 1; k <= NREQ; k++) begin
        w_idx = rr_idx(r_ptr, k);
        if (!w_found && req_valid[w_idx]) begin
          w_found        = 1'b1;
          w_gnt          = w_idx;
          w_ready[w_idx] = 1'b1;
        end
      end
    end
  end

  // Select the winning requester's address and data for the write stage.
  always_comb begin
    w_addr = req_addr[int'(w_gnt)*AW +: AW];
    w_data = req_data[int'(w_gnt)*N +: N];
  end

  assign req_ready = w_ready;

  // ---- stage p0: registered write port, pointer and commit counter ----
  // Capture the accepted request; idle cycles clear the strobes only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr    <= 2'(NREQ - 1);
      r_we3_p0 <= 1'b0;
      r_wa3_p0 <= '0;
      r_wd3_p0 <= '0;
      r_gid_p0 <= '0;
      r_zd_p0  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_found) begin
      r_ptr    <= w_gnt;
      r_wa3_p0 <= w_addr;
      r_wd3_p0 <= w_data;
      r_gid_p0 <= w_gnt;
      if (w_addr != '0) begin
        r_we3_p0 <= 1'b1;
        r_zd_p0  <= 1'b0;
        r_cnt    <= sat_inc(r_cnt);
      end else begin
        r_we3_p0 <= 1'b0;
        r_zd_p0  <= 1'b1;
      end
    end else begin
      r_we3_p0 <= 1'b0;
      r_zd_p0  <= 1'b0;
    end
  end

  assign wa3       = r_wa3_p0;
  assign wd3       = r_wd3_p0;
  assign we3       = r_we3_p0;
  assign grant_id  = r_gid_p0;
  assign zero_drop = r_zd_p0;
  assign wr_count  = r_cnt;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: reset and round-robin sequences, a vector
// table, randomized traffic against a behavioural model, counter saturation
// and reset while a write is pending.
module tb_regfile_wr_arbiter;

  localparam int N    = 8;
  localparam int NREQ = 3;
  localparam int AW   = 5;

  logic                clk;
  logic                rst;
  logic                stall;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*N-1:0]   req_data;
  logic [NREQ-1:0]     req_ready;
  logic [AW-1:0]       wa3;
  logic [N-1:0]        wd3;
  logic                we3;
  logic [1:0]          grant_id;
  logic                zero_drop;
  logic [15:0]         wr_count;

  regfile_wr_arbiter #(.N(N), .NREQ(NREQ), .AW(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wa3(wa3), .wd3(wd3), .we3(we3),
    .grant_id(grant_id), .zero_drop(zero_drop), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state: last winner and the expected write-port view.
  int m_ptr, m_we3, m_wa3, m_wd3, m_gid, m_zd, m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int addr_of(input int i);
    return int'(req_addr[i*AW +: AW]);
  endfunction

  function automatic int data_of(input int i);
    return int'(req_data[i*N +: N]);
  endfunction

  // Winner = first valid requester in the rotation that begins after the
  // previous winner; nobody wins during reset or stall.
  function automatic int model_pick();
    int order[$];
    if (!rst || stall) return -1;
    for (int k = 1; k <= NREQ; k++) order.push_back((m_ptr + k) % NREQ);
    foreach (order[j]) if (req_valid[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = NREQ - 1; m_we3 = 0; m_wa3 = 0; m_wd3 = 0;
    m_gid = 0; m_zd = 0; m_cnt = 0;
  endtask

  // One clock: inputs already driven after a negedge. Checks ready before the
  // edge, advances the model, checks registered outputs after it, and
  // returns at the next negedge.
  task automatic step(output int g);
    logic [NREQ-1:0] exp_rdy;
    #1;
    g = model_pick();
    exp_rdy = (g < 0) ? '0 : NREQ'(1 << g);
    chk("ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst) model_reset();
    else if (g >= 0) begin
      m_ptr = g; m_gid = g;
      m_wa3 = addr_of(g); m_wd3 = data_of(g);
      if (m_wa3 != 0) begin
        m_we3 = 1; m_zd = 0;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else begin
        m_we3 = 0; m_zd = 1;
      end
    end else begin
      m_we3 = 0; m_zd = 0;
    end
    #1;
    chk("we3", 32'(we3), 32'(m_we3));
    chk("wa3", 32'(wa3), 32'(m_wa3));
    chk("wd3", 32'(wd3), 32'(m_wd3));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("zero_drop", 32'(zero_drop), 32'(m_zd));
    chk("wr_count", 32'(wr_count), 32'(m_cnt));
    @(negedge clk);
  endtask

  typedef struct {
    logic [NREQ-1:0]    valid;
    logic               stall;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*N-1:0]  data;
    logic [NREQ-1:0]    exp_ready;
    logic               exp_we3;
    logic [AW-1:0]      exp_wa3;
    logic [N-1:0]       exp_wd3;
    logic [1:0]         exp_gid;
    logic               exp_zd;
    logic [15:0]        exp_cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int g;
    logic [NREQ*AW-1:0] a123;
    logic [NREQ*N-1:0]  d123;
    a123 = {5'd3, 5'd2, 5'd1};
    d123 = {8'h30, 8'h20, 8'h10};

    // Vectors start from reset (first scan begins at requester 0).
    tbl[0] = '{3'b010, 1'b0, {5'd0, 5'd5, 5'd0}, {8'h00, 8'hA7, 8'h00}, 3'b010, 1'b1, 5'd5, 8'hA7, 2'd1, 1'b0, 16'd1};
    tbl[1] = '{3'b111, 1'b0, a123, d123, 3'b100, 1'b1, 5'd3, 8'h30, 2'd2, 1'b0, 16'd2};
    tbl[2] = '{3'b111, 1'b0, a123, d123, 3'b001, 1'b1, 5'd1, 8'h10, 2'd0, 1'b0, 16'd3};
    tbl[3] = '{3'b111, 1'b0, a123, d123, 3'b010, 1'b1, 5'd2, 8'h20, 2'd1, 1'b0, 16'd4};
    tbl[4] = '{3'b111, 1'b1, a123, d123, 3'b000, 1'b0, 5'd2, 8'h20, 2'd1, 1'b0, 16'd4};
    tbl[5] = '{3'b111, 1'b0, a123, d123, 3'b100, 1'b1, 5'd3, 8'h30, 2'd2, 1'b0, 16'd5};
    tbl[6] = '{3'b100, 1'b0, {5'd0, 5'd2, 5'd1}, {8'hFF, 8'h20, 8'h10}, 3'b100, 1'b0, 5'd0, 8'hFF, 2'd2, 1'b1, 16'd5};
    tbl[7] = '{3'b000, 1'b0, a123, d123, 3'b000, 1'b0, 5'd0, 8'hFF, 2'd2, 1'b0, 16'd5};
    tbl[8] = '{3'b001, 1'b0, a123, d123, 3'b001, 1'b1, 5'd1, 8'h10, 2'd0, 1'b0, 16'd6};
    tbl[9] = '{3'b001, 1'b0, {5'd3, 5'd2, 5'd9}, {8'h30, 8'h20, 8'h5C}, 3'b001, 1'b1, 5'd9, 8'h5C, 2'd0, 1'b0, 16'd7};

    model_reset();
    rst = 1'b0; stall = 1'b0; req_valid = '1; req_addr = a123; req_data = d123;
    @(negedge clk);

    // Reset held two cycles with every requester valid.
    for (int c = 0; c < 2; c++) begin
      #1 chk("reset_ready", 32'(req_ready), 32'd0);
      step(g);
    end

    // Round-robin from reset with all requesters valid.
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_order", 32'(req_ready), 32'(3'b001 << (k % 3)));
      step(g);
    end
    chk("rr_count", 32'(wr_count), 32'd6);

    // Vector table, starting from a fresh reset.
    rst = 1'b0; step(g); rst = 1'b1;
    for (int v = 0; v < 10; v++) begin
      req_valid = tbl[v].valid; stall = tbl[v].stall;
      req_addr = tbl[v].addr; req_data = tbl[v].data;
      #1 chk($sformatf("tbl%0d_ready", v), 32'(req_ready), 32'(tbl[v].exp_ready));
      step(g);
      chk($sformatf("tbl%0d_we3", v), 32'(we3), 32'(tbl[v].exp_we3));
      chk($sformatf("tbl%0d_wa3", v), 32'(wa3), 32'(tbl[v].exp_wa3));
      chk($sformatf("tbl%0d_wd3", v), 32'(wd3), 32'(tbl[v].exp_wd3));
      chk($sformatf("tbl%0d_gid", v), 32'(grant_id), 32'(tbl[v].exp_gid));
      chk($sformatf("tbl%0d_zd", v), 32'(zero_drop), 32'(tbl[v].exp_zd));
      chk($sformatf("tbl%0d_cnt", v), 32'(wr_count), 32'(tbl[v].exp_cnt));
    end

    // Randomized traffic: requesters hold their request until accepted.
    req_valid = '0;
    g = -1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && g != i)) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_addr[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          req_data[i*N +: N] = N'($urandom);
        end
      end
      stall = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) != 0);
      step(g);
    end

    // Saturation: a lone requester writing well past 65535 commits.
    rst = 1'b1; stall = 1'b0; req_valid = 3'b001;
    req_addr = {5'd3, 5'd2, 5'd7}; req_data = {8'h30, 8'h20, 8'h42};
    repeat (65537) @(posedge clk);
    #1;
    chk("sat_count", 32'(wr_count), 32'h0000FFFF);
    chk("sat_we3", 32'(we3), 32'd1);
    @(negedge clk);

    // Reset while a write is pending cancels it and clears the counter.
    rst = 1'b0;
    #1 chk("midrst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_we3", 32'(we3), 32'd0);
    chk("midrst_cnt", 32'(wr_count), 32'd0);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    step(g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Round-robin arbiter that shares the register file's single write port (wa3/wd3/we3) among NREQ requesters, e.g. ALU writeback, load unit and debug/console writer. Each requester uses a valid/ready handshake. The granted request is registered and driven to the register file one cycle later. The block also drops writes to register 0 and counts committed writes.

Parameters:
N, 8, data width (matches register file data width)
NREQ, 3, number of requesters (2..4)
AW, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
stall  in  1  when high, no grant is issued this cycle
req_valid  in  NREQ  per-requester write request
req_addr  in  NREQ*AW  packed addresses; requester i at bits [i*AW +: AW]
req_data  in  NREQ*N  packed data; requester i at bits [i*N +: N]
req_ready  out  NREQ  one-hot grant/accept, combinational
wa3  out  AW  register file write address, registered
wd3  out  N  register file write data, registered
we3  out  1  register file write enable, registered
grant_id  out  2  index of the requester that produced the current wa3/wd3, registered
zero_drop  out  1  one-cycle pulse: an accepted request targeted register 0
wr_count  out  16  committed write count, saturating

Behaviour:
- Reset (rst==0 at posedge clk):
  - we3=0, wa3=0, wd3=0, grant_id=0, zero_drop=0, wr_count=0.
  - Round-robin pointer ptr=NREQ-1, so requester 0 has first priority after reset.
- req_ready while rst==0: all bits forced to 0 (combinational), so no handshake completes in a reset cycle.
- Arbitration (combinational, each cycle):
  - If stall==0, scan indices ptr+1, ptr+2, … modulo NREQ.
  - The first index with req_valid set gets req_ready=1; all other bits are 0.
  - If stall==1 or no valid is set, req_ready is all zeros.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i].
  - Requesters hold valid, addr and data stable until accepted.
  - Ready never asserts without valid.
- Pointer: on a transfer from requester i, ptr<=i. Otherwise ptr holds.
- Write pipeline (latency 1): on the posedge that completes a transfer from requester i:
  - wa3<=req_addr[i], wd3<=req_data[i], grant_id<=i.
  - If addr!=0: we3<=1, wr_count<=wr_count+1, saturating at 16'hFFFF.
  - If addr==0: we3<=0, zero_drop<=1, wr_count unchanged.
- Idle cycles (no transfer, including stall): we3<=0 and zero_drop<=0. wa3, wd3 and grant_id hold their last values.
- Throughput:
  - One write per cycle is sustained.
  - Back-to-back grants to different requesters are allowed.
  - A lone requester holding valid is granted every cycle.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,… and each is served within NREQ cycles.
- Reset mid-operation:
  - An in-flight registered write is cancelled: we3=0 on the cycle after reset is sampled.
  - Requests pending during reset are not accepted and must be re-presented.
- grant_id width is fixed at 2, so NREQ must not exceed 4.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all req_valid=1 -> req_ready=000, we3=0, wr_count=0. After release, the first grant goes to requester 0.
- Single requester: req_valid=010, addr=5, data=8'hA7 -> req_ready=010 in the same cycle. Next cycle we3=1, wa3=5, wd3=A7, grant_id=1, wr_count=1.
- Round-robin: all three valid for 6 cycles with distinct addresses 1/2/3 -> grant order 0,1,2,0,1,2, six we3 pulses, wr_count=6.
- Register 0 drop: requester 2 writes addr=0, data=8'hFF -> ready asserted, next cycle we3=0 and zero_drop=1, wr_count unchanged.
- Stall: stall=1 for 3 cycles with req_valid=111 -> req_ready=000 and we3=0. After stall drops, the grant resumes at ptr+1 and no request is lost.
- Saturation and mid-reset:
  - Preload by running 65537 writes -> wr_count=FFFF, no wrap.
  - Assert rst=0 while we3 is pending -> we3=0 and wr_count=0 on the following cycle.
